// File: rtl/config_pkg.sv
// Minimal core-configuration package holding only the fields the discovery responder exposes.
// The empty configuration keeps a one-bit transaction ID so port widths stay legal.
package config_pkg;

    typedef struct packed {
        logic [31:0] XLEN;
        logic        RVA;
        logic        RVB;
        logic        RVC;
        logic        RVF;
        logic        RVD;
        logic        RVH;
        logic        RVV;
        logic        RVZCB;
        logic        RVZCMP;
        logic        RVZiCond;
        logic        RVS;
        logic        RVU;
        logic        CvxifEn;
        logic        RVZcheripurecap;
        logic        RVZcherihybrid;
        logic        DebugEn;
        logic        MmuPresent;
        logic        PerfCounterEn;
        logic [31:0] IcacheByteSize;
        logic [31:0] IcacheSetAssoc;
        logic [31:0] IcacheLineWidth;
        logic [31:0] DcacheByteSize;
        logic [31:0] DcacheSetAssoc;
        logic [31:0] DcacheLineWidth;
        logic [31:0] NrScoreboardEntries;
        logic [31:0] NrCommitPorts;
        logic [31:0] NrPMPEntries;
        logic [31:0] WtDcacheWbufDepth;
        logic [63:0] HaltAddress;
        logic [63:0] ExceptionAddress;
        logic [63:0] DmBaseAddress;
        logic [31:0] BTBEntries;
        logic [31:0] BHTEntries;
        logic [31:0] MemTidWidth;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{MemTidWidth: 32'd1, default: '0};

endpackage

// File: rtl/cva6_cfg_discovery.sv
// Read-only discovery responder returning a fixed word map of CVA6Cfg through a 2-entry queue.
// Define CVA6_CFG_DISCOVERY_CHECKSUM_EN to add word 10, an XOR of words 0-9 walked after reset.
module cva6_cfg_discovery #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
    parameter int unsigned           AddrWidth = 12,
    parameter int unsigned           TidWidth  = CVA6Cfg.MemTidWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [TidWidth-1:0]  tid_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [63:0]          rdata_o,
    output logic [TidWidth-1:0]  rtid_o,
    output logic                 err_o
);

    localparam int unsigned IdxWidth = AddrWidth - 3;
    localparam logic [63:0] Magic    = 64'h4356_4136_4346_4730;
`ifdef CVA6_CFG_DISCOVERY_CHECKSUM_EN
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(10);
`else
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(9);
`endif

    typedef enum logic {StInit, StReady} state_e;

    function automatic logic [63:0] cfg_word(input logic [3:0] idx);
        case (idx)
            4'd0: return Magic;
            4'd1: return 64'(CVA6Cfg.XLEN);
            4'd2: return {46'b0, CVA6Cfg.PerfCounterEn, CVA6Cfg.MmuPresent, CVA6Cfg.DebugEn,
                          CVA6Cfg.RVZcherihybrid, CVA6Cfg.RVZcheripurecap, CVA6Cfg.CvxifEn,
                          CVA6Cfg.RVU, CVA6Cfg.RVS, CVA6Cfg.RVZiCond, CVA6Cfg.RVZCMP,
                          CVA6Cfg.RVZCB, CVA6Cfg.RVV, CVA6Cfg.RVH, CVA6Cfg.RVD, CVA6Cfg.RVF,
                          CVA6Cfg.RVC, CVA6Cfg.RVB, CVA6Cfg.RVA};
            4'd3: return {CVA6Cfg.IcacheByteSize, CVA6Cfg.DcacheByteSize};
            4'd4: return {CVA6Cfg.IcacheSetAssoc[15:0], CVA6Cfg.IcacheLineWidth[15:0],
                          CVA6Cfg.DcacheSetAssoc[15:0], CVA6Cfg.DcacheLineWidth[15:0]};
            4'd5: return {CVA6Cfg.NrScoreboardEntries[15:0], CVA6Cfg.NrCommitPorts[15:0],
                          CVA6Cfg.NrPMPEntries[15:0], CVA6Cfg.WtDcacheWbufDepth[15:0]};
            4'd6: return CVA6Cfg.HaltAddress;
            4'd7: return CVA6Cfg.ExceptionAddress;
            4'd8: return CVA6Cfg.DmBaseAddress;
            4'd9: return {CVA6Cfg.BTBEntries, CVA6Cfg.BHTEntries};
            default: return '0;
        endcase
    endfunction

    state_e                     state_q, state_d;
    logic [1:0]                 count_q, count_d;
    logic                       wr_ptr_q, wr_ptr_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic [1:0][63:0]           data_q, data_d;
    logic [1:0][TidWidth-1:0]   tid_q, tid_d;
    logic [1:0]                 err_q, err_d;
`ifdef CVA6_CFG_DISCOVERY_CHECKSUM_EN
    logic [3:0]                 cnt_q, cnt_d;
    logic [63:0]                acc_q, acc_d;
`endif

    logic                       full, push, pop;
    logic [IdxWidth-1:0]        idx;
    logic                       resp_err;
    logic [63:0]                resp_data;

    assign full     = (count_q == 2'd2);
    // Grant depends only on state and occupancy, so a same-cycle pop never frees a slot.
    assign gnt_o    = (state_q == StReady) && !full;
    assign push     = req_i && gnt_o;
    assign rvalid_o = (count_q != 2'd0);
    assign pop      = rvalid_o && rready_i;
    assign idx      = addr_i[AddrWidth-1:3];
    assign resp_err = we_i || (|addr_i[2:0]) || (idx > LastIdx);

    assign rdata_o  = rvalid_o ? data_q[rd_ptr_q] : '0;
    assign rtid_o   = rvalid_o ? tid_q[rd_ptr_q]  : '0;
    assign err_o    = rvalid_o && err_q[rd_ptr_q];

    always_comb begin
        resp_data = '0;
        if (!resp_err) begin
            resp_data = cfg_word(idx[3:0]);
`ifdef CVA6_CFG_DISCOVERY_CHECKSUM_EN
            if (idx == LastIdx) resp_data = acc_q;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef CVA6_CFG_DISCOVERY_CHECKSUM_EN
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (state_q == StInit) begin
            acc_d = acc_q ^ cfg_word(cnt_q);
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) state_d = StReady;
        end
`else
        if (state_q == StInit) state_d = StReady;
`endif
    end

    always_comb begin
        data_d   = data_q;
        tid_d    = tid_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            data_d[wr_ptr_q] = resp_data;
            tid_d[wr_ptr_q]  = tid_i;
            err_d[wr_ptr_q]  = resp_err;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StInit;
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            data_q   <= '0;
            tid_q    <= '0;
            err_q    <= '0;
`ifdef CVA6_CFG_DISCOVERY_CHECKSUM_EN
            cnt_q    <= '0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            tid_q    <= tid_d;
            err_q    <= err_d;
`ifdef CVA6_CFG_DISCOVERY_CHECKSUM_EN
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_cva6_cfg_discovery.sv
// Directed self-checking bench for cva6_cfg_discovery on a typical 64-bit configuration.
module tb_cva6_cfg_discovery;

    localparam config_pkg::cva6_cfg_t Cfg = '{
        XLEN: 32'd64,
        RVA: 1'b1, RVB: 1'b0, RVC: 1'b0, RVF: 1'b1, RVD: 1'b1, RVH: 1'b1, RVV: 1'b0,
        RVZCB: 1'b1, RVZCMP: 1'b0, RVZiCond: 1'b1, RVS: 1'b1, RVU: 1'b1, CvxifEn: 1'b0,
        RVZcheripurecap: 1'b0, RVZcherihybrid: 1'b0, DebugEn: 1'b1, MmuPresent: 1'b1,
        PerfCounterEn: 1'b1,
        IcacheByteSize: 32'd16384, IcacheSetAssoc: 32'd4, IcacheLineWidth: 32'd128,
        DcacheByteSize: 32'd32768, DcacheSetAssoc: 32'd8, DcacheLineWidth: 32'd128,
        NrScoreboardEntries: 32'd8, NrCommitPorts: 32'd2, NrPMPEntries: 32'd8,
        WtDcacheWbufDepth: 32'd8,
        HaltAddress: 64'h800, ExceptionAddress: 64'h808, DmBaseAddress: 64'h1000,
        BTBEntries: 32'd32, BHTEntries: 32'd128, MemTidWidth: 32'd4
    };

    localparam logic [63:0] W0 = 64'h4356_4136_4346_4730;
    localparam logic [63:0] W1 = 64'd64;
    localparam logic [63:0] W2 = 64'h0000_0000_0003_8EB9;
    localparam logic [63:0] W3 = 64'h0000_4000_0000_8000;
    localparam logic [63:0] W4 = 64'h0004_0080_0008_0080;
    localparam logic [63:0] W5 = 64'h0008_0002_0008_0008;
    localparam logic [63:0] W6 = 64'h0000_0000_0000_0800;
    localparam logic [63:0] W7 = 64'h0000_0000_0000_0808;
    localparam logic [63:0] W8 = 64'h0000_0000_0000_1000;
    localparam logic [63:0] W9 = 64'h0000_0020_0000_0080;
`ifdef CVA6_CFG_DISCOVERY_CHECKSUM_EN
    localparam int          ExpInit = 10;
    localparam logic [63:0] ExpW10  = W0 ^ W1 ^ W2 ^ W3 ^ W4 ^ W5 ^ W6 ^ W7 ^ W8 ^ W9;
    localparam logic        ExpE10  = 1'b0;
`else
    localparam int          ExpInit = 1;
    localparam logic [63:0] ExpW10  = 64'h0;
    localparam logic        ExpE10  = 1'b1;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i, we_i, rready_i;
    logic [11:0] addr_i;
    logic [3:0]  tid_i;
    logic        gnt_o, rvalid_o, err_o;
    logic [63:0] rdata_o;
    logic [3:0]  rtid_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    cva6_cfg_discovery #(
        .CVA6Cfg   (Cfg),
        .AddrWidth (12),
        .TidWidth  (4)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .tid_i    (tid_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rready_i (rready_i),
        .rdata_o  (rdata_o),
        .rtid_o   (rtid_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (!gnt_o && cyc < 40) begin
            step();
            cyc++;
        end
        chk(tag, 64'(cyc), 64'(ExpInit));
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; tid_i = '0; rready_i = 1'b1;
        repeat (3) step();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_rtid", rtid_o, 0);
        chk("rst_err", err_o, 0);
        rst_i = 1'b0;
        wait_ready("init_len");

        // Magic read, then words 1 and 2 back-to-back.
        req_i = 1'b1; addr_i = 12'h000; tid_i = 4'd2;
        step();
        chk("magic_rvalid", rvalid_o, 1);
        chk("magic_rdata", rdata_o, W0);
        chk("magic_rtid", rtid_o, 2);
        chk("magic_err", err_o, 0);
        addr_i = 12'h008; tid_i = 4'd3;
        step();
        chk("xlen_rdata", rdata_o, W1);
        chk("xlen_rtid", rtid_o, 3);
        addr_i = 12'h010; tid_i = 4'd4;
        step();
        req_i = 1'b0;
        chk("isa_rdata", rdata_o, W2);
        chk("isa_rtid", rtid_o, 4);
        chk("isa_err", err_o, 0);
        step();
        chk("drain_rvalid", rvalid_o, 0);

        // Error cases, last word and the optional checksum word.
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h000; tid_i = 4'd5;
        step();
        we_i = 1'b0; addr_i = 12'h004; tid_i = 4'd6;
        chk("wr_err", err_o, 1);
        chk("wr_rdata", rdata_o, 0);
        chk("wr_rtid", rtid_o, 5);
        step();
        addr_i = 12'h058; tid_i = 4'd7;
        chk("misal_err", err_o, 1);
        chk("misal_rdata", rdata_o, 0);
        step();
        addr_i = 12'h048; tid_i = 4'd8;
        chk("oor_err", err_o, 1);
        chk("oor_rdata", rdata_o, 0);
        chk("oor_rtid", rtid_o, 7);
        step();
        addr_i = 12'h050; tid_i = 4'd9;
        chk("w9_rdata", rdata_o, W9);
        chk("w9_err", err_o, 0);
        step();
        req_i = 1'b0;
        chk("w10_rdata", rdata_o, ExpW10);
        chk("w10_err", err_o, ExpE10);
        step();
        chk("drain2_rvalid", rvalid_o, 0);

        // Backpressure: fill the queue, then pulse rready for one cycle.
        rready_i = 1'b0; req_i = 1'b1; addr_i = 12'h018; tid_i = 4'd1;
        chk("bp_gnt0", gnt_o, 1);
        step();
        addr_i = 12'h020; tid_i = 4'd2;
        chk("bp_gnt1", gnt_o, 1);
        step();
        addr_i = 12'h028; tid_i = 4'd3;
        chk("bp_full_gnt", gnt_o, 0);
        chk("bp_head_rdata", rdata_o, W3);
        chk("bp_head_rtid", rtid_o, 1);
        step();
        chk("bp_hold_gnt", gnt_o, 0);
        chk("bp_hold_rdata", rdata_o, W3);
        rready_i = 1'b1;
        chk("bp_pop_gnt", gnt_o, 0);
        step();
        rready_i = 1'b0;
        chk("bp_regrant", gnt_o, 1);
        chk("bp_w4_rdata", rdata_o, W4);
        chk("bp_w4_rtid", rtid_o, 2);
        step();
        req_i = 1'b0;
        chk("bp_w4_hold", rdata_o, W4);
        rready_i = 1'b1;
        step();
        chk("bp_w5_rdata", rdata_o, W5);
        chk("bp_w5_rtid", rtid_o, 3);
        step();
        chk("bp_empty", rvalid_o, 0);

        // Reset with two responses queued.
        rready_i = 1'b0; req_i = 1'b1; addr_i = 12'h030; tid_i = 4'd1;
        step();
        addr_i = 12'h038; tid_i = 4'd2;
        step();
        req_i = 1'b0;
        chk("q2_rvalid", rvalid_o, 1);
        chk("q2_rdata", rdata_o, W6);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_rvalid", rvalid_o, 0);
        chk("mid_rst_gnt", gnt_o, 0);
        repeat (2) step();
        rst_i = 1'b0; rready_i = 1'b1;
        wait_ready("reinit_len");
        chk("no_stale", rvalid_o, 0);
        req_i = 1'b1; addr_i = 12'h040; tid_i = 4'hF;
        step();
        req_i = 1'b0;
        chk("post_rst_rdata", rdata_o, W8);
        chk("post_rst_rtid", rtid_o, 4'hF);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cva6_cfg_discovery.md
# cva6_cfg_discovery

Read-only, memory-mapped discovery responder that lets software and the debug module read back the core configuration carried in `CVA6Cfg`. It sits on the peripheral request/grant/response port beside the debug ROM. Granted requests return a fixed 64-bit word map derived at elaboration from `CVA6Cfg`, in order, through a two-entry response queue. An optional integrity word is computed sequentially after reset.

## Interface
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`: core configuration that is exposed.
- `AddrWidth`, 12: byte-address width of the window.
- `TidWidth`, `CVA6Cfg.MemTidWidth`: transaction ID width.
- `clk_i  in  1`: clock.
- `rst_i  in  1`: asynchronous, active-high reset.
- `req_i  in  1`: request valid.
- `we_i  in  1`: write request; always answered with an error.
- `addr_i  in  AddrWidth`: byte address.
- `tid_i  in  TidWidth`: request ID.
- `gnt_o  out  1`: request accepted this cycle when high together with `req_i`.
- `rvalid_o  out  1`: response valid.
- `rready_i  in  1`: response consumed when high together with `rvalid_o`.
- `rdata_o  out  64`: response data.
- `rtid_o  out  TidWidth`: echoed `tid_i`.
- `err_o  out  1`: response is an error.

## Operation
- Word index is `addr_i[AddrWidth-1:3]`. Any nonzero `addr_i[2:0]` is an error.
- Word map. Fields are zero-extended, or truncated to the stated width.
  - Word 0: magic `64'h4356_4136_4346_4730`.
  - Word 1: `XLEN`.
  - Word 2: ISA mask. Bits 0–17 are RVA, RVB, RVC, RVF, RVD, RVH, RVV, RVZCB, RVZCMP, RVZiCond, RVS, RVU, CvxifEn, RVZcheripurecap, RVZcherihybrid, DebugEn, MmuPresent, PerfCounterEn. Remaining bits are 0.
  - Word 3: `{IcacheByteSize[31:0], DcacheByteSize[31:0]}`.
  - Word 4: `{IcacheSetAssoc[15:0], IcacheLineWidth[15:0], DcacheSetAssoc[15:0], DcacheLineWidth[15:0]}`.
  - Word 5: `{NrScoreboardEntries[15:0], NrCommitPorts[15:0], NrPMPEntries[15:0], WtDcacheWbufDepth[15:0]}`.
  - Word 6: `HaltAddress`.
  - Word 7: `ExceptionAddress`.
  - Word 8: `DmBaseAddress`.
  - Word 9: `{BTBEntries[31:0], BHTEntries[31:0]}`.
  - Word 10: checksum; present only with the macro.
- Error responses (`err_o=1`, `rdata_o=0`) are returned for:
  - a write;
  - a misaligned address;
  - an index beyond the last present word.
- Error responses change no state.
- FSM states are `INIT` and `READY`.
  - Reset enters `INIT`.
  - `INIT` → `READY` when the checksum walk completes. Without the macro, `INIT` lasts exactly one cycle.
  - `READY` is terminal until the next reset.
- Response queue:
  - Two entries, FIFO order, each holding {rdata, rtid, err}.
  - `gnt_o = (state==READY) && !full`. It does not depend on `req_i`.
  - If the queue is full, no grant is issued, even when a pop happens in the same cycle.
  - A push and a pop in the same cycle keep the count unchanged.
- Reset at any point, including mid-walk or with the queue occupied:
  - clears the queue;
  - returns the FSM to `INIT`;
  - discards pending responses without signalling them.

## Timing
- Values during and after reset: `gnt_o=0`, `rvalid_o=0`, `rdata_o=0`, `rtid_o=0`, `err_o=0`.
- Latency: a request accepted in cycle N yields `rvalid_o=1` in cycle N+1 if the queue was empty. Otherwise it follows the older entries.
- `rdata_o`, `rtid_o` and `err_o` are held stable while `rvalid_o && !rready_i`.
- Peak throughput is one request per cycle while `rready_i` stays high.
- `gnt_o` first rises:
  - with the macro, 10 cycles after `rst_i` deasserts;
  - without the macro, 1 cycle after `rst_i` deasserts.

## Configuration
- Macro: `CVA6_CFG_DISCOVERY_CHECKSUM_EN`.
- Defined:
  - In `INIT`, a 4-bit counter walks words 0–9, one per cycle, XOR-accumulating into a 64-bit register.
  - After index 9 the FSM moves to `READY`.
  - Word 10 returns the accumulated XOR; the last valid index is 10.
- Undefined:
  - No counter or accumulator exists.
  - Word 10 is out of range and returns an error; the last valid index is 9.

## Test plan
- Reset, then read `addr_i=0x000`, `tid_i=2`, with `rready_i=1` → next cycle: `rvalid_o=1`, `rdata_o=64'h4356_4136_4346_4730`, `rtid_o=2`, `err_o=0`.
- Read `0x008` and `0x010` back-to-back on the default 64-bit config → responses in order:
  - first: `rdata_o=64`;
  - second: bit0 RVA=1, bit2 RVC=0, bit5 RVH=1, bit9 RVZiCond=1, bit13=0.
- Write to `0x000`, read `0x004`, read `0x058` → three responses, each `err_o=1` and `rdata_o=0`.
- Hold `rready_i=0` and issue 3 reads → first two granted, `gnt_o=0` on the third. Pulse `rready_i` for one cycle → one entry pops. The third read is granted only in the following cycle.
- Assert `rst_i` with two responses queued → `rvalid_o=0` immediately and no stale response after deassert. With the macro, `gnt_o` stays low for 10 cycles after deassert.
- With the macro: read `0x050` → XOR of words 0–9. Without the macro: read `0x050` → `err_o=1`.
